// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache line refill engine:
// FSM state encoding and the memory word width.
package icache_refill_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/icache_refill.sv
// Critical-word-first instruction-cache line refill: fetches one line from
// memory starting at the missing word, wrapping within the line.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_data_i,
  output logic              fill_we_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic [WORD_W-1:0] fill_data_o,
  output logic              fill_done_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W    = $clog2(LINE_WORDS);
  localparam int unsigned LINE_LSB = IDX_W + 2;

  typedef logic [IDX_W-1:0] idx_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;
  idx_t              offset;
  idx_t              count;
  logic [ADDR_W-1:0] req_addr;
  logic              start;
  logic              take;
  logic              last;
  logic              miss_byte_unused;

  function automatic idx_t wrap_inc(input idx_t v);
    return v + idx_t'(1);
  endfunction

  assign miss_byte_unused = ^miss_addr_i[1:0];

  assign start = (state == ST_IDLE) && miss_i && !flush_i;
  assign take  = (state == ST_REQ) && mem_ack_i && !flush_i;
  assign last  = (count == idx_t'(LINE_WORDS - 1));

  // Base has its line-offset bits cleared, so inserting the word index never carries.
  always_comb begin
    req_addr                 = base;
    req_addr[LINE_LSB-1:2]   = offset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        if (flush_i)          state_nxt = ST_IDLE;
        else if (take && last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = (state == ST_REQ);
    mem_addr_o  = (state == ST_REQ) ? req_addr : '0;
    busy_o      = (state != ST_IDLE);
    fill_done_o = (state == ST_DONE) && !flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base   <= '0;
      offset <= '0;
      count  <= '0;
    end else if (start) begin
      base   <= {miss_addr_i[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
      offset <= miss_addr_i[LINE_LSB-1:2];
      count  <= '0;
    end else if (take) begin
      offset <= wrap_inc(offset);
      count  <= count + idx_t'(1);
    end
  end

  // A flush in the ack cycle cancels the write that would follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_we_o   <= 1'b0;
      fill_addr_o <= '0;
      fill_data_o <= '0;
    end else begin
      fill_we_o <= take;
      if (take) begin
        fill_addr_o <= req_addr;
        fill_data_o <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for icache_refill (LINE_WORDS=4, ADDR_W=32).
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_i;
  logic [31:0] miss_addr_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        fill_we_o;
  logic [31:0] fill_addr_o;
  logic [31:0] fill_data_o;
  logic        fill_done_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] fa_q[$];
  logic [31:0] fd_q[$];
  int          fc_q[$];
  int          done_q[$];
  int          stab_err = 0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;

  icache_refill #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .fill_we_o(fill_we_o),
    .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .fill_done_o(fill_done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fill_we_o) begin
      fa_q.push_back(fill_addr_o);
      fd_q.push_back(fill_data_o);
      fc_q.push_back(cyc);
    end
    if (fill_done_o) done_q.push_back(cyc);
    if (prev_pending && mem_req_o && mem_addr_o != prev_addr) stab_err++;
    prev_pending = mem_req_o && !mem_ack_i;
    prev_addr    = mem_addr_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    fa_q.delete(); fd_q.delete(); fc_q.delete(); done_q.delete();
  endtask

  task automatic miss_go(input logic [31:0] addr);
    miss_i = 1'b1;
    miss_addr_i = addr;
    step();
    miss_i = 1'b0;
  endtask

  // Serve n words, holding ack low for 'waits' cycles before each ack.
  task automatic serve(input int n, input int waits);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < waits; w++) begin
        mem_ack_i = 1'b0;
        step();
      end
      check($sformatf("req_w%0d", i), mem_req_o, 1'b1);
      mem_ack_i  = 1'b1;
      mem_data_i = mem_addr_o ^ 32'hCAFE_0000;
      step();
    end
    mem_ack_i = 1'b0;
  endtask

  task automatic check_fills(input string tag, input int n,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3);
    logic [31:0] e[4];
    e = '{a0, a1, a2, a3};
    check($sformatf("%s_nfill", tag), fa_q.size(), n);
    for (int i = 0; i < n && i < fa_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), fa_q[i], e[i]);
      check($sformatf("%s_data%0d", tag, i), fd_q[i], e[i] ^ 32'hCAFE_0000);
    end
  endtask

  int c0;
  int req_seen;

  initial begin
    rst = 1'b1; miss_i = 1'b0; miss_addr_i = '0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    #12;
    check("rst_req", mem_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_outs", {fill_we_o, fill_done_o, mem_addr_o, fill_addr_o}, '0);
    check("rst_data", fill_data_o, '0);
    rst = 1'b0;
    step();

    // Ack every cycle, miss at 0x108: latency and critical-word-first order
    clear_log();
    c0 = cyc;
    miss_go(32'h108);
    serve(4, 0);
    check("t1_done_busy", busy_o, 1'b1);
    check("t1_done_req", mem_req_o, 1'b0);
    step();
    check("t1_idle_busy", busy_o, 1'b0);
    check_fills("t1", 4, 32'h108, 32'h10C, 32'h100, 32'h104);
    check("t1_first_fill_cyc", (fc_q.size() > 0) ? fc_q[0] - c0 : -1, 2);
    check("t1_ndone", done_q.size(), 1);
    check("t1_done_cyc", (done_q.size() > 0) ? done_q[0] - c0 : -1, 5);
    check("t1_done_with_last_fill",
          (done_q.size() > 0 && fc_q.size() == 4) ? done_q[0] - fc_q[3] : -1, 0);

    // Ack delayed 3 cycles per word
    clear_log();
    miss_go(32'h108);
    serve(4, 3);
    step(); step();
    check_fills("t2", 4, 32'h108, 32'h10C, 32'h100, 32'h104);
    check("t2_ndone", done_q.size(), 1);

    // Flush after the 2nd ack, then a fresh miss at 0x200
    clear_log();
    miss_go(32'h108);
    serve(2, 0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("t3_busy_after_flush", busy_o, 1'b0);
    check("t3_req_after_flush", mem_req_o, 1'b0);
    step(); step();
    check_fills("t3a", 2, 32'h108, 32'h10C, 32'h0, 32'h0);
    check("t3a_ndone", done_q.size(), 0);
    clear_log();
    miss_go(32'h200);
    serve(4, 0);
    step(); step();
    check_fills("t3b", 4, 32'h200, 32'h204, 32'h208, 32'h20C);
    check("t3b_ndone", done_q.size(), 1);

    // Flush in the same cycle as an ack suppresses that word's fill
    clear_log();
    miss_go(32'h108);
    mem_ack_i = 1'b1; flush_i = 1'b1; mem_data_i = 32'h1234_5678;
    step();
    mem_ack_i = 1'b0; flush_i = 1'b0;
    check("t4_busy", busy_o, 1'b0);
    step(); step();
    check("t4_nfill", fa_q.size(), 0);

    // Flush during DONE drops fill_done
    clear_log();
    miss_go(32'h40);
    serve(4, 0);
    flush_i = 1'b1;
    #1;
    check("t5_done_masked", fill_done_o, 1'b0);
    step();
    flush_i = 1'b0;
    check("t5_busy", busy_o, 1'b0);
    check("t5_ndone", done_q.size(), 0);

    // Flush and miss together in IDLE: no refill
    miss_i = 1'b1; flush_i = 1'b1; miss_addr_i = 32'h500;
    step();
    miss_i = 1'b0; flush_i = 1'b0;
    check("t6_busy", busy_o, 1'b0);
    check("t6_req", mem_req_o, 1'b0);

    // Top of address space, with a second miss held high while busy
    clear_log();
    miss_go(32'hFFFF_FFFC);
    miss_i = 1'b1; miss_addr_i = 32'h300;
    serve(4, 0);
    miss_i = 1'b0;
    step(); step();
    check("t7_busy", busy_o, 1'b0);
    check("t7_req", mem_req_o, 1'b0);
    check_fills("t7", 4, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8);
    check("t7_ndone", done_q.size(), 1);

    // Asynchronous reset mid-refill
    miss_go(32'h108);
    serve(2, 0);
    #2 rst = 1'b1;
    #1;
    check("t8_req", mem_req_o, 1'b0);
    check("t8_busy", busy_o, 1'b0);
    check("t8_outs", {fill_we_o, fill_done_o, mem_addr_o, fill_addr_o}, '0);
    check("t8_data", fill_data_o, '0);
    #3 rst = 1'b0;
    clear_log();
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req_o || busy_o) req_seen++;
    end
    check("t8_no_restart", req_seen, 0);
    check("t8_nfill", fa_q.size(), 0);
    miss_go(32'h108);
    serve(4, 0);
    step(); step();
    check_fills("t8r", 4, 32'h108, 32'h10C, 32'h100, 32'h104);

    check("addr_stable", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
